// File: rtl/round_scheduler.sv
// round_scheduler: round-robin sharing of one iterative cipher round datapath between two requesters (optional ABORT_EN adds abort/aborted)
module round_scheduler #(
  parameter int ROUNDS = 17,
  parameter int CNT_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic             req1_valid,
  output logic             req1_ready,
  output logic             dp_load,
  output logic             dp_round_en,
  output logic [CNT_W-1:0] dp_round,
  output logic             dp_last,
  output logic             grant_id,
  output logic             busy,
  output logic             done_valid,
  output logic             done_id,
  input  logic             done_ready
`ifdef ABORT_EN
  ,
  input  logic             abort,
  output logic             aborted
`endif
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ROUNDS - 1);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic rr_q, rr_d, gid_q, gid_d;
`ifdef ABORT_EN
  logic abt_q, abt_d;
`endif
  // Arbitration, job sequencing and round counter next-state
  always_comb begin
    req0_ready = state_q == IDLE && req0_valid && (!req1_valid || !rr_q);
    req1_ready = state_q == IDLE && req1_valid && (!req0_valid || rr_q);
    state_d = state_q;
    cnt_d = cnt_q;
    rr_d = rr_q;
    gid_d = gid_q;
    case (state_q)
      IDLE: if (req0_ready || req1_ready) begin
        state_d = LOAD;
        cnt_d = '0;
        gid_d = req1_ready;
        rr_d = ~req1_ready;
      end
      LOAD: state_d = RUN;
      RUN: if (cnt_q == LAST) state_d = DONE; else cnt_d = cnt_q + CNT_W'(1);
      DONE: if (done_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef ABORT_EN
    abt_d = abort && (state_q == LOAD || state_q == RUN);
    if (abt_d) begin
      state_d = IDLE;
      cnt_d = '0;
    end
`endif
  end
  // State, counter, round-robin pointer and owner registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rr_q <= 1'b0;
      gid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rr_q <= rr_d;
      gid_q <= gid_d;
    end
  end
`ifdef ABORT_EN
  // One-cycle pulse following an accepted abort
  always_ff @(posedge clk or posedge rst) begin
    if (rst) abt_q <= 1'b0;
    else abt_q <= abt_d;
  end
  assign aborted = abt_q;
`endif
  assign dp_load     = state_q == LOAD;
  assign dp_round_en = state_q == RUN;
  assign dp_round    = state_q == RUN ? cnt_q : '0;
  assign dp_last     = state_q == RUN && cnt_q == LAST;
  assign busy        = state_q != IDLE;
  assign done_valid  = state_q == DONE;
  assign done_id     = state_q == DONE && gid_q;
  assign grant_id    = gid_q;
endmodule

// File: tb/tb_round_scheduler.sv
// tb_round_scheduler: directed table-driven and sequence checks for round_scheduler
module tb_round_scheduler;
  logic clk = 1'b0, rst = 1'b1;
  logic req0_valid = 1'b0, req1_valid = 1'b0, done_ready = 1'b0;
  logic req0_ready, req1_ready, dp_load, dp_round_en, dp_last, grant_id, busy, done_valid, done_id;
  logic [4:0] dp_round;
`ifdef ABORT_EN
  logic abort = 1'b0, aborted;
`endif
  int checks = 0, errors = 0;
  logic [13:0] act;
  typedef struct {
    logic [2:0]  stim;
    logic [13:0] exp;
  } vec_t;
  vec_t vecs[24];

  round_scheduler #(.ROUNDS(17), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .dp_load(dp_load), .dp_round_en(dp_round_en), .dp_round(dp_round), .dp_last(dp_last),
    .grant_id(grant_id), .busy(busy), .done_valid(done_valid), .done_id(done_id),
    .done_ready(done_ready)
`ifdef ABORT_EN
    , .abort(abort), .aborted(aborted)
`endif
  );

  always #5 clk = ~clk;
  assign act = {req0_ready, req1_ready, dp_load, dp_round_en, dp_round, dp_last, busy, done_valid, done_id, grant_id};

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, a, e);
    end
  endtask

  function automatic logic [13:0] ex(input logic [3:0] a, input logic [4:0] rnd, input logic [4:0] b);
    return {a, rnd, b};
  endfunction

  task automatic setv(input int i, input logic [2:0] s, input logic [13:0] e);
    vecs[i].stim = s;
    vecs[i].exp = e;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    done_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic launch0_wait(input logic [4:0] rnd, input string name);
    @(negedge clk);
    req0_valid = 1'b1;
    @(negedge clk);
    req0_valid = 1'b0;
    for (int c = 0; c < 40 && !(dp_round_en && dp_round == rnd); c++) @(negedge clk);
    chk(name, {dp_round_en, dp_round}, {1'b1, rnd});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int n, last_t;
    // stim = {req0_valid, req1_valid, done_ready}
    setv(0, 3'b000, ex(4'b0000, 5'd0, 5'b00000));
    setv(1, 3'b100, ex(4'b1000, 5'd0, 5'b00000));
    setv(2, 3'b000, ex(4'b0010, 5'd0, 5'b01000));
    setv(3, 3'b000, ex(4'b0001, 5'd0, 5'b01000));
    for (int i = 4; i < 20; i++) setv(i, 3'b010, ex(4'b0001, 5'(i - 3), {i == 19, 4'b1000}));
    setv(20, 3'b010, ex(4'b0000, 5'd0, 5'b01100));
    setv(21, 3'b011, ex(4'b0000, 5'd0, 5'b01100));
    setv(22, 3'b010, ex(4'b0100, 5'd0, 5'b00000));
    setv(23, 3'b000, ex(4'b0010, 5'd0, 5'b01001));

    do_reset();
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      {req0_valid, req1_valid, done_ready} = vecs[i].stim;
      #1;
      chk($sformatf("vec%0d", i), act, vecs[i].exp);
    end

    do_reset();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    done_ready = 1'b1;
    n = 0;
    last_t = 0;
    for (int c = 0; c < 100 && n < 4; c++) begin
      @(negedge clk);
      #1;
      if (dp_load) begin
        chk($sformatf("rr_grant%0d", n), grant_id, n[0]);
        if (n > 0) chk($sformatf("job_period%0d", n), c - last_t, 20);
        last_t = c;
        n++;
      end
    end
    chk("rr_grant_count", n, 4);

    do_reset();
    launch0_wait(5'd16, "reach_last");
    for (int c = 0; c < 5 && !done_valid; c++) @(negedge clk);
    chk("reach_done", done_valid, 1);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    done_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("done_hold%0d", i), {done_valid, done_id, req0_ready, req1_ready}, 4'b1000);
    end
    done_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("done_release", {busy, done_valid, req0_ready, req1_ready}, 4'b0001);

    do_reset();
    launch0_wait(5'd8, "reach_r8");
    #2 rst = 1'b1;
    #1 chk("async_rst", act, 14'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1 chk("post_rst_idle", act, 14'd0);
    req0_valid = 1'b1;
    #1 chk("post_rst_ready", act, ex(4'b1000, 5'd0, 5'b00000));
    @(negedge clk);
    req0_valid = 1'b0;
    #1 chk("post_rst_load", act, ex(4'b0010, 5'd0, 5'b01000));
    @(negedge clk);
    #1 chk("post_rst_r0", act, ex(4'b0001, 5'd0, 5'b01000));

`ifdef ABORT_EN
    do_reset();
    launch0_wait(5'd5, "reach_r5");
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1 chk("abort_pulse", {aborted, busy, done_valid}, 3'b100);
    @(negedge clk);
    #1 chk("abort_end", {aborted, busy, done_valid}, 3'b000);
    launch0_wait(5'd16, "abort_job2_last");
    @(negedge clk);
    chk("abort_job2_done", done_valid, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1 chk("abort_in_done", {done_valid, aborted}, 2'b10);
    done_ready = 1'b1;
    @(negedge clk);
    done_ready = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
